// File: rtl/segment_frame_decoder.sv
// segment_frame_decoder
// Recovers the intended segment pattern from a fixed number of displayed
// frames. It counts how often each segment bit was ON, then threshold-votes
// every bit in parallel. One decoded word per run is offered on a
// valid/ready result port.
module segment_frame_decoder #(
  parameter int RND_SIZE   = 77,
  parameter int NUM_FRAMES = 16,
  parameter int CNT_W      = $clog2(NUM_FRAMES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    threshold,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [RND_SIZE-1:0] frame,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_seen,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [RND_SIZE-1:0] result
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(NUM_FRAMES);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [RND_SIZE];
  logic [CNT_W-1:0]    cnt_d [RND_SIZE];
  logic [CNT_W-1:0]    seen_q, seen_d;
  logic [CNT_W-1:0]    thr_q, thr_d;
  logic [RND_SIZE-1:0] result_q, result_d;
  logic                accept;

  // All status outputs are decoded from registered state only, so no input
  // can reach an output combinationally.
  assign frame_ready  = (state_q == ST_ACCUM);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign frames_seen  = seen_q;
  assign result       = result_q;
  assign accept       = frame_ready && frame_valid;

  // Next-state, counter, threshold and result logic for one run.
  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    thr_d    = thr_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACCUM;
          seen_d   = '0;
          thr_d    = threshold;
          result_d = '0;
          for (int i = 0; i < RND_SIZE; i++) cnt_d[i] = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          seen_d = seen_q + CNT_W'(1);
          for (int i = 0; i < RND_SIZE; i++) cnt_d[i] = cnt_q[i] + CNT_W'(frame[i]);
          if (seen_d == LAST_FRAME) state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        for (int i = 0; i < RND_SIZE; i++) result_d[i] = (cnt_q[i] >= thr_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything so an aborted run leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      seen_q   <= '0;
      thr_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < RND_SIZE; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      thr_q    <= thr_d;
      result_q <= result_d;
      for (int i = 0; i < RND_SIZE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_segment_frame_decoder.sv
// tb_segment_frame_decoder
// Table-driven full runs plus hand-written sequences for reset, handshake
// stalls and ignored start pulses.
module tb_segment_frame_decoder;

  localparam int RS = 77;
  localparam int NF = 16;
  localparam int CW = 5;

  localparam logic [RS-1:0] ONE  = RS'(1);
  localparam logic [RS-1:0] ALL1 = {RS{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] threshold;
  logic          frame_valid;
  logic          frame_ready;
  logic [RS-1:0] frame;
  logic          busy;
  logic [CW-1:0] frames_seen;
  logic          result_valid;
  logic          result_ready;
  logic [RS-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string         name;
    logic [CW-1:0] thr;
    logic [RS-1:0] base;
    logic [RS-1:0] mask_a;
    int            n_a;
    logic [RS-1:0] mask_b;
    int            n_b;
    logic [RS-1:0] exp_result;
  } vec_t;

  vec_t vecs [6];

  segment_frame_decoder #(.RND_SIZE(RS), .NUM_FRAMES(NF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .threshold    (threshold),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame        (frame),
    .busy         (busy),
    .frames_seen  (frames_seen),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [RS-1:0] act, input logic [RS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete run with continuous frame_valid and result_ready raised early.
  task automatic applyStimulus(input logic [CW-1:0] thr, input logic [RS-1:0] base,
                               input logic [RS-1:0] ma, input int na,
                               input logic [RS-1:0] mb, input int nb,
                               output logic [RS-1:0] res, output int lat,
                               output logic [CW-1:0] seen);
    @(negedge clk);
    start = 1'b1;
    threshold = thr;
    @(negedge clk);
    start = 1'b0;
    threshold = '0;
    checkOutput("ready_after_start", RS'(frame_ready), RS'(1));
    checkOutput("busy_after_start", RS'(busy), RS'(1));
    for (int k = 0; k < NF; k++) begin
      frame_valid = 1'b1;
      frame = base | ((k < na) ? ma : '0) | ((k < nb) ? mb : '0);
      @(negedge clk);
    end
    frame_valid = 1'b0;
    frame = '0;
    result_ready = 1'b1;
    lat = 1;
    while (!result_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    seen = frames_seen;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("busy_after_handshake", RS'(busy), RS'(0));
    checkOutput("valid_after_handshake", RS'(result_valid), RS'(0));
  endtask

  initial begin
    logic [RS-1:0] res;
    logic [CW-1:0] seen;
    int            lat;
    int            acc;
    int            cyc;
    bit            pulsed;

    vecs[0] = '{"full_on_thr8",    5'd8,  ALL1,      '0,        0,  '0,        0, ALL1};
    vecs[1] = '{"per_bit_thr8",    5'd8,  ONE << 76, ONE,       8,  ONE << 1,  7, ONE | (ONE << 76)};
    vecs[2] = '{"thr0_all_zero",   5'd0,  '0,        '0,        0,  '0,        0, ALL1};
    vecs[3] = '{"thr17_all_ones",  5'd17, ALL1,      '0,        0,  '0,        0, '0};
    vecs[4] = '{"thr16_edge",      5'd16, ONE << 5,  ONE << 10, 15, '0,        0, ONE << 5};
    vecs[5] = '{"thr1_single",     5'd1,  '0,        ONE << 3,  1,  ONE << 40, 0, ONE << 3};

    rst_n = 1'b1;
    start = 1'b0;
    threshold = '0;
    frame_valid = 1'b0;
    frame = '0;
    result_ready = 1'b0;

    // Asynchronous reset asserted between clock edges.
    #12 rst_n = 1'b0;
    #1;
    checkOutput("rst_frame_ready", RS'(frame_ready), RS'(0));
    checkOutput("rst_busy", RS'(busy), RS'(0));
    checkOutput("rst_frames_seen", RS'(frames_seen), RS'(0));
    checkOutput("rst_result_valid", RS'(result_valid), RS'(0));
    checkOutput("rst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_frame_ready", RS'(frame_ready), RS'(0));

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].thr, vecs[v].base, vecs[v].mask_a, vecs[v].n_a,
                    vecs[v].mask_b, vecs[v].n_b, res, lat, seen);
      checkOutput({vecs[v].name, "_result"}, res, vecs[v].exp_result);
      checkOutput({vecs[v].name, "_latency"}, RS'(lat), RS'(2));
      checkOutput({vecs[v].name, "_frames_seen"}, RS'(seen), RS'(NF));
    end

    // Stress: random gaps, ignored start in ACCUM, stalled result handshake.
    @(negedge clk);
    start = 1'b1;
    threshold = 5'd10;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (acc < NF && cyc < 400) begin
      frame_valid = ($urandom_range(0, 2) != 0);
      frame = ((acc < 10) ? ONE : '0) | ((acc < 9) ? (ONE << 1) : '0);
      if (acc == 6 && !pulsed) begin
        start = 1'b1;
        threshold = 5'd3;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (frame_valid && frame_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    frame_valid = 1'b0;
    frame = '0;
    checkOutput("stress_accept_budget", RS'(acc), RS'(NF));
    checkOutput("stress_frames_seen", RS'(frames_seen), RS'(NF));
    checkOutput("stress_decide_not_valid", RS'(result_valid), RS'(0));
    @(negedge clk);
    checkOutput("stress_valid", RS'(result_valid), RS'(1));
    checkOutput("stress_result_thr10", result, ONE);
    frame_valid = 1'b1;
    frame = ALL1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("stall_valid_held", RS'(result_valid), RS'(1));
      checkOutput("stall_result_held", result, ONE);
      checkOutput("stall_frames_seen", RS'(frames_seen), RS'(NF));
    end
    frame_valid = 1'b0;
    frame = '0;
    result_ready = 1'b1;
    start = 1'b1;
    threshold = 5'd3;
    @(negedge clk);
    start = 1'b0;
    result_ready = 1'b0;
    checkOutput("stress_return_idle", RS'(busy), RS'(0));
    checkOutput("stress_valid_drop", RS'(result_valid), RS'(0));
    @(negedge clk);
    checkOutput("start_on_return_ignored", RS'(busy), RS'(0));

    // Reset in the middle of a run, then a fresh run.
    @(negedge clk);
    start = 1'b1;
    threshold = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frame_valid = 1'b1;
      frame = ALL1;
      @(negedge clk);
    end
    frame_valid = 1'b0;
    frame = '0;
    checkOutput("midrun_frames_seen", RS'(frames_seen), RS'(5));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_frames_seen", RS'(frames_seen), RS'(0));
    checkOutput("midrun_rst_busy", RS'(busy), RS'(0));
    checkOutput("midrun_rst_frame_ready", RS'(frame_ready), RS'(0));
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("midrun_no_valid", RS'(result_valid), RS'(0));
    end
    rst_n = 1'b1;
    applyStimulus(5'd3, '0, ONE << 2, 3, '0, 0, res, lat, seen);
    checkOutput("after_rst_result", res, ONE << 2);
    checkOutput("after_rst_latency", RS'(lat), RS'(2));
    checkOutput("after_rst_frames_seen", RS'(seen), RS'(NF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
